// File: rtl/alu.sv
// 32-bit combinational integer ALU built from 32 ripple-carry 1-bit slices.
// Supports AND/OR/ADD/SUB/SLT/NOR and reports zero, carry-out and signed overflow.
module alu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic [3:0]  ALU_control,
  output logic [31:0] result,
  output logic        zero,
  output logic        cout,
  output logic        overflow
);

  typedef struct packed {
    logic res;
    logic co;
  } slice_t;

  // One bit of the datapath: optional operand inversion, full adder and op mux.
  function automatic slice_t alu_slice(
    input logic       a,
    input logic       b,
    input logic       less,
    input logic       ainv,
    input logic       binv,
    input logic       cin,
    input logic [1:0] op
  );
    slice_t s;
    logic   a_s;
    logic   b_s;
    a_s  = a ^ ainv;
    b_s  = b ^ binv;
    s.co = (a_s & b_s) | (a_s & cin) | (b_s & cin);
    case (op)
      2'b00:   s.res = a_s & b_s;
      2'b01:   s.res = a_s | b_s;
      2'b10:   s.res = a_s ^ b_s ^ cin;
      2'b11:   s.res = less;
      default: s.res = 1'b0;
    endcase
    return s;
  endfunction

  logic        unused_clk_s;
  logic        ainv_s;
  logic        binv_s;
  logic [1:0]  op_s;
  logic [31:0] slice_res_s;
  logic        c_in31_s;
  logic        c_out_s;
  logic        sum31_s;
  logic        ovf_s;
  logic        set_s;
  logic        op_valid_s;
  logic        op_arith_s;

  assign unused_clk_s = clk;
  assign ainv_s       = ALU_control[3];
  assign binv_s       = ALU_control[2];
  assign op_s         = ALU_control[1:0];

  // Ripple chain through the slices; bit0 is redone with the corrected SLT set bit.
  always_comb begin
    slice_t sl;
    logic   carry;
    slice_res_s = 32'h0000_0000;
    carry       = binv_s;
    for (int i = 0; i < 31; i++) begin
      sl             = alu_slice(src1[i], src2[i], 1'b0, ainv_s, binv_s, carry, op_s);
      slice_res_s[i] = sl.res;
      carry          = sl.co;
    end
    c_in31_s        = carry;
    sl              = alu_slice(src1[31], src2[31], 1'b0, ainv_s, binv_s, c_in31_s, op_s);
    slice_res_s[31] = sl.res;
    c_out_s         = sl.co;
    sum31_s         = (src1[31] ^ ainv_s) ^ (src2[31] ^ binv_s) ^ c_in31_s;
    ovf_s           = c_in31_s ^ c_out_s;
    // Raw sign is wrong when the subtraction overflows, so fold the overflow back in.
    set_s           = sum31_s ^ ovf_s;
    sl              = alu_slice(src1[0], src2[0], set_s, ainv_s, binv_s, binv_s, op_s);
    slice_res_s[0]  = sl.res;
  end

  // Decode which control codes are legal and which drive the adder flags.
  always_comb begin
    op_valid_s = 1'b0;
    op_arith_s = 1'b0;
    case (ALU_control)
      4'b0000: op_valid_s = 1'b1;
      4'b0001: op_valid_s = 1'b1;
      4'b0010: begin
        op_valid_s = 1'b1;
        op_arith_s = 1'b1;
      end
      4'b0110: begin
        op_valid_s = 1'b1;
        op_arith_s = 1'b1;
      end
      4'b0111: op_valid_s = 1'b1;
      4'b1100: op_valid_s = 1'b1;
      default: begin
        op_valid_s = 1'b0;
        op_arith_s = 1'b0;
      end
    endcase
  end

  // Output stage: reset clamps everything low, illegal codes yield a zero result.
  always_comb begin
    result   = 32'h0000_0000;
    zero     = 1'b0;
    cout     = 1'b0;
    overflow = 1'b0;
    if (!rst_n) begin
      result   = 32'h0000_0000;
      zero     = 1'b0;
      cout     = 1'b0;
      overflow = 1'b0;
    end else if (!op_valid_s) begin
      result   = 32'h0000_0000;
      zero     = 1'b1;
      cout     = 1'b0;
      overflow = 1'b0;
    end else begin
      result   = slice_res_s;
      zero     = ~|slice_res_s;
      cout     = op_arith_s ? c_out_s : 1'b0;
      overflow = op_arith_s ? ovf_s : 1'b0;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Table-driven bench for the combinational ALU plus hand-written reset sequences.
module tb_alu;

  logic        clk;
  logic        rst_n;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [3:0]  ALU_control;
  logic [31:0] result;
  logic        zero;
  logic        cout;
  logic        overflow;

  int n_pass;
  int n_total;

  alu dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .src1       (src1),
    .src2       (src2),
    .ALU_control(ALU_control),
    .result     (result),
    .zero       (zero),
    .cout       (cout),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  ctl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    logic [2:0]  exp_zcv;
  } vec_t;

  localparam logic [3:0] C_AND = 4'b0000;
  localparam logic [3:0] C_OR  = 4'b0001;
  localparam logic [3:0] C_ADD = 4'b0010;
  localparam logic [3:0] C_SUB = 4'b0110;
  localparam logic [3:0] C_SLT = 4'b0111;
  localparam logic [3:0] C_NOR = 4'b1100;

  vec_t vecs[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    vecs.push_back('{"add_ovf",     C_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 3'b001});
    vecs.push_back('{"add_wrap",    C_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 3'b110});
    vecs.push_back('{"add_plain",   C_ADD, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 3'b000});
    vecs.push_back('{"add_min2",    C_ADD, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 3'b111});
    vecs.push_back('{"sub_eq",      C_SUB, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 3'b110});
    vecs.push_back('{"sub_ovf",     C_SUB, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 3'b011});
    vecs.push_back('{"sub_borrow",  C_SUB, 32'h0000_0001, 32'h0000_0002, 32'hFFFF_FFFF, 3'b000});
    vecs.push_back('{"slt_neg",     C_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 3'b000});
    vecs.push_back('{"slt_min",     C_SLT, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 3'b000});
    vecs.push_back('{"slt_eq",      C_SLT, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 3'b100});
    vecs.push_back('{"slt_vs_min",  C_SLT, 32'h0000_0001, 32'h8000_0000, 32'h0000_0000, 3'b100});
    vecs.push_back('{"slt_max_m1",  C_SLT, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 3'b100});
    vecs.push_back('{"slt_small",   C_SLT, 32'h0000_0003, 32'h0000_0010, 32'h0000_0001, 3'b000});
    vecs.push_back('{"and",         C_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 3'b000});
    vecs.push_back('{"and_zero",    C_AND, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'h0000_0000, 3'b100});
    vecs.push_back('{"or",          C_OR,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 3'b000});
    vecs.push_back('{"nor_zero",    C_NOR, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 3'b000});
    vecs.push_back('{"nor_ones",    C_NOR, 32'hFFFF_0000, 32'h0000_FFFF, 32'h0000_0000, 3'b100});
    vecs.push_back('{"undef_0011",  4'b0011, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 3'b100});
    vecs.push_back('{"undef_1111",  4'b1111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 3'b100});

    // Reset clamps all outputs regardless of inputs.
    rst_n       = 1'b0;
    ALU_control = C_ADD;
    src1        = 32'h0000_0001;
    src2        = 32'h0000_0001;
    #7;
    check("rst_result", result, 32'h0000_0000);
    check("rst_zcv", {29'd0, zero, cout, overflow}, 32'd0);
    ALU_control = 4'b0011;
    #2;
    check("rst_undef_zcv", {29'd0, zero, cout, overflow}, 32'd0);
    ALU_control = C_ADD;

    // Release between clock edges: output must follow without any clk edge.
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("rel_result", result, 32'h0000_0002);
    check("rel_zcv", {29'd0, zero, cout, overflow}, 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      ALU_control = vecs[i].ctl;
      src1        = vecs[i].a;
      src2        = vecs[i].b;
      #5;
      check({vecs[i].name, "_res"}, result, vecs[i].exp_res);
      check({vecs[i].name, "_zcv"}, {29'd0, zero, cout, overflow}, {29'd0, vecs[i].exp_zcv});
    end

    // Re-assert reset mid-operation on an overflowing SUB, then release again.
    ALU_control = C_SUB;
    src1        = 32'h8000_0000;
    src2        = 32'h0000_0001;
    #1;
    rst_n = 1'b0;
    #1;
    check("rst2_result", result, 32'h0000_0000);
    check("rst2_zcv", {29'd0, zero, cout, overflow}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("rel2_result", result, 32'h7FFF_FFFF);
    check("rel2_zcv", {29'd0, zero, cout, overflow}, 32'b011);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
